e203_nice_csr_master: RTL and testbench



---
 rtl/e203_nice_csr_master.sv | 141 ++++++++++++++
 tb/tb_e203_nice_csr_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/e203_nice_csr_master.sv
//==============================================================================
// Module      : e203_nice_csr_master
// Description : Core-side initiator for the extended-CSR NICE handshake.
//               Accepts one CSR access from the EXU CSR stage and presents it
//               to the extended-CSR responder. It then returns the sampled
//               read data, or a timeout error, on a valid/ready response
//               channel.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module e203_nice_csr_master #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    // Core CSR request channel
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [11:0] csr_req_addr,
    input  logic        csr_req_wr,
    input  logic [31:0] csr_req_wdata,

    // Core CSR response channel
    output logic        csr_rsp_valid,
    input  logic        csr_rsp_ready,
    output logic [31:0] csr_rsp_rdata,
    output logic        csr_rsp_err,

    // Extended-CSR responder interface
    output logic        nice_csr_valid,
    input  logic        nice_csr_ready,
    output logic [31:0] nice_csr_addr,
    output logic        nice_csr_wr,
    output logic [31:0] nice_csr_wdata,
    input  logic [31:0] nice_csr_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e             state_q;
    logic [11:0]        addr_q;
    logic               wr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               w_timeout_hit;

    // Terminal-count detect; a TIMEOUT of zero removes the guard entirely.
    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam logic [CNT_W-1:0] c_term_cnt = CNT_W'(TIMEOUT - 1);
            assign w_timeout_hit = (cnt_q == c_term_cnt);
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // Saturating increment so the counter never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Access sequencer: latch request, wait for responder or timeout, hold
    // the response until the core consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 12'd0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csr_req_valid) begin
                        addr_q  <= csr_req_addr;
                        wr_q    <= csr_req_wr;
                        wdata_q <= csr_req_wdata;
                        cnt_q   <= '0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ready has priority over the timeout terminal count.
                    if (nice_csr_ready) begin
                        rdata_q <= nice_csr_rdata;
                        err_q   <= 1'b0;
                        state_q <= ST_RSP;
                    end else if (w_timeout_hit) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                        state_q <= ST_RSP;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                ST_RSP: begin
                    if (csr_rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // All handshake outputs decode from the state register only, so no
    // responder input can reach the core request channel combinationally.
    assign csr_req_ready  = (state_q == ST_IDLE);
    assign nice_csr_valid = (state_q == ST_REQ);
    assign csr_rsp_valid  = (state_q == ST_RSP);
    assign busy           = (state_q != ST_IDLE);

    assign nice_csr_addr  = {20'd0, addr_q};
    assign nice_csr_wr    = wr_q;
    assign nice_csr_wdata = wdata_q;
    assign csr_rsp_rdata  = rdata_q;
    assign csr_rsp_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_e203_nice_csr_master.sv
//==============================================================================
// Module      : tb_e203_nice_csr_master
// Description : Directed self-checking bench for e203_nice_csr_master.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_e203_nice_csr_master;

    logic        clk;
    logic        rst_n;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [11:0] csr_req_addr;
    logic        csr_req_wr;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_err;
    logic        nice_csr_valid;
    logic        nice_csr_ready;
    logic [31:0] nice_csr_addr;
    logic        nice_csr_wr;
    logic [31:0] nice_csr_wdata;
    logic [31:0] nice_csr_rdata;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    e203_nice_csr_master #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_req_valid  (csr_req_valid),
        .csr_req_ready  (csr_req_ready),
        .csr_req_addr   (csr_req_addr),
        .csr_req_wr     (csr_req_wr),
        .csr_req_wdata  (csr_req_wdata),
        .csr_rsp_valid  (csr_rsp_valid),
        .csr_rsp_ready  (csr_rsp_ready),
        .csr_rsp_rdata  (csr_rsp_rdata),
        .csr_rsp_err    (csr_rsp_err),
        .nice_csr_valid (nice_csr_valid),
        .nice_csr_ready (nice_csr_ready),
        .nice_csr_addr  (nice_csr_addr),
        .nice_csr_wr    (nice_csr_wr),
        .nice_csr_wdata (nice_csr_wdata),
        .nice_csr_rdata (nice_csr_rdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then act as responder. rdy_cycle is the 1-based REQ
    // cycle on which ready is raised (0 = never). Returns the number of
    // cycles nice_csr_valid was seen high and how many of those had unstable
    // addr/wr/wdata.
    task automatic run_access(input logic [11:0] a, input logic w, input logic [31:0] wd,
                              input int rdy_cycle, input logic [31:0] rd,
                              output int vcycles, output int unstable);
        csr_req_valid = 1'b1;
        csr_req_addr  = a;
        csr_req_wr    = w;
        csr_req_wdata = wd;
        tick();
        csr_req_valid = 1'b0;
        csr_req_addr  = 12'hFFF;
        csr_req_wr    = ~w;
        csr_req_wdata = 32'hFFFF_FFFF;
        vcycles  = 0;
        unstable = 0;
        for (int i = 1; i <= 50; i++) begin
            if (!nice_csr_valid) break;
            vcycles++;
            if (nice_csr_addr !== {20'd0, a} || nice_csr_wr !== w || nice_csr_wdata !== wd)
                unstable++;
            nice_csr_ready = (i == rdy_cycle);
            nice_csr_rdata = (i == rdy_cycle) ? rd : (32'hA5A5_0000 | 32'(i));
            tick();
        end
        nice_csr_ready = 1'b0;
        nice_csr_rdata = 32'hCAFE_F00D;
    endtask

    task automatic finish_rsp(input string tag);
        csr_rsp_ready = 1'b1;
        tick();
        csr_rsp_ready = 1'b0;
        check({tag, "_req_ready_after"}, 32'(csr_req_ready), 32'd1);
        check({tag, "_rsp_valid_after"}, 32'(csr_rsp_valid), 32'd0);
    endtask

    initial begin
        int vc;
        int us;
        int bp_bad;

        rst_n          = 1'b0;
        csr_req_valid  = 1'b0;
        csr_req_addr   = 12'd0;
        csr_req_wr     = 1'b0;
        csr_req_wdata  = 32'd0;
        csr_rsp_ready  = 1'b0;
        nice_csr_ready = 1'b0;
        nice_csr_rdata = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready",  32'(csr_req_ready),  32'd1);
        check("rst_nice_valid", 32'(nice_csr_valid), 32'd0);
        check("rst_rsp_valid",  32'(csr_rsp_valid),  32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_nice_addr",  nice_csr_addr,       32'd0);
        check("rst_nice_wdata", nice_csr_wdata,      32'd0);
        check("rst_nice_wr",    32'(nice_csr_wr),    32'd0);
        check("rst_rsp_rdata",  csr_rsp_rdata,       32'd0);
        check("rst_rsp_err",    32'(csr_rsp_err),    32'd0);
        rst_n = 1'b1;
        tick();

        // Read, responder ready in the first REQ cycle
        run_access(12'hBC0, 1'b0, 32'd0, 1, 32'hDEAD_BEEF, vc, us);
        check("rd_valid_cycles", 32'(vc), 32'd1);
        check("rd_stable",       32'(us), 32'd0);
        check("rd_rsp_valid",    32'(csr_rsp_valid), 32'd1);
        check("rd_rsp_rdata",    csr_rsp_rdata,      32'hDEAD_BEEF);
        check("rd_rsp_err",      32'(csr_rsp_err),   32'd0);
        check("rd_busy",         32'(busy),          32'd1);
        finish_rsp("rd");

        // Write with ready on the third REQ cycle
        run_access(12'h7C1, 1'b1, 32'h1234_5678, 3, 32'h0BAD_F00D, vc, us);
        check("wr_valid_cycles", 32'(vc), 32'd3);
        check("wr_stable",       32'(us), 32'd0);
        check("wr_rsp_valid",    32'(csr_rsp_valid), 32'd1);
        check("wr_rsp_rdata",    csr_rsp_rdata,      32'h0BAD_F00D);
        check("wr_rsp_err",      32'(csr_rsp_err),   32'd0);
        finish_rsp("wr");

        // Timeout with the responder silent
        run_access(12'h801, 1'b0, 32'h0, 0, 32'h0, vc, us);
        check("to_valid_cycles", 32'(vc), 32'd4);
        check("to_stable",       32'(us), 32'd0);
        check("to_rsp_valid",    32'(csr_rsp_valid), 32'd1);
        check("to_rsp_rdata",    csr_rsp_rdata,      32'd0);
        check("to_rsp_err",      32'(csr_rsp_err),   32'd1);
        finish_rsp("to");

        // Ready coincides with the timeout terminal count
        run_access(12'h802, 1'b0, 32'h0, 4, 32'h600D_CAFE, vc, us);
        check("co_valid_cycles", 32'(vc), 32'd4);
        check("co_rsp_rdata",    csr_rsp_rdata,    32'h600D_CAFE);
        check("co_rsp_err",      32'(csr_rsp_err), 32'd0);
        finish_rsp("co");

        // Response backpressure with a competing request pending
        run_access(12'h345, 1'b0, 32'h0, 1, 32'h55AA_1234, vc, us);
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h300;
        csr_req_wr    = 1'b1;
        csr_req_wdata = 32'h9999_9999;
        bp_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (csr_rsp_valid !== 1'b1 || csr_rsp_rdata !== 32'h55AA_1234 ||
                csr_rsp_err !== 1'b0 || csr_req_ready !== 1'b0 || nice_csr_valid !== 1'b0)
                bp_bad++;
            tick();
        end
        check("bp_hold", 32'(bp_bad), 32'd0);
        check("bp_nice_addr", nice_csr_addr, 32'h0000_0345);
        csr_req_valid = 1'b0;
        finish_rsp("bp");
        check("bp_no_accept", 32'(nice_csr_valid), 32'd0);

        // Reset asserted mid-REQ
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'h123;
        csr_req_wr    = 1'b0;
        tick();
        csr_req_valid = 1'b0;
        check("mr_nice_valid_pre", 32'(nice_csr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_nice_valid", 32'(nice_csr_valid), 32'd0);
        check("mr_rsp_valid",  32'(csr_rsp_valid),  32'd0);
        check("mr_req_ready",  32'(csr_req_ready),  32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_no_rsp", 32'(csr_rsp_valid), 32'd0);
        check("mr_ready",  32'(csr_req_ready), 32'd1);
        run_access(12'hABC, 1'b1, 32'hFEED_0001, 2, 32'h1357_9BDF, vc, us);
        check("mr_new_cycles", 32'(vc), 32'd2);
        check("mr_new_rdata",  csr_rsp_rdata,    32'h1357_9BDF);
        check("mr_new_err",    32'(csr_rsp_err), 32'd0);
        finish_rsp("mr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
